// File: rtl/tm1638_frame_sched_if.sv
// Byte handshake and strobe between the TM1638 frame scheduler and the serial shifter.
interface tm1638_frame_sched_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       shifter_busy;
    logic       stb;

    modport master (
        output byte_out,
        output byte_valid,
        output stb,
        input  byte_ready,
        input  shifter_busy
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        input  stb,
        output byte_ready,
        output shifter_busy
    );
endinterface

// File: rtl/tm1638_frame_sched.sv
// TM1638 frame scheduler: on each tick, sends three strobed command groups
// (0x40 | 0xC0 + 16 data bytes | display control) to a byte-wide serial shifter.
// Optional macro TM1638_LEADZERO_BLANK_EN blanks zero digits at even positions.
module tm1638_frame_sched #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [7:0]                  led,
    input  logic [3:0]                  seg0,
    input  logic [3:0]                  seg1,
    input  logic [3:0]                  seg2,
    input  logic [3:0]                  seg3,
    input  logic [3:0]                  seg4,
    input  logic [3:0]                  seg5,
    input  logic [3:0]                  seg6,
    input  logic [3:0]                  seg7,
    input  logic [2:0]                  bright,
    input  logic                        disp_on,
    tm1638_frame_sched_if.master        bus,
    output logic                        busy,
    output logic                        frame_done
);

    typedef enum logic [2:0] {
        StIdle, StG1, StGap1, StG2, StGap2, StG3, StGap3, StDone
    } state_e;

    state_e      state_q, state_d;
    logic        stb_q, stb_d;
    logic        valid_q, valid_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  addr_q, addr_d;
    logic        data_q, data_d;      // G2 is past its 0xC0 header
    logic [15:0] gap_q, gap_d;
    logic        pending_q, pending_d;
    logic [7:0]  led_q, led_d;
    logic [3:0]  seg_q [8];
    logic [3:0]  seg_d [8];
    logic [2:0]  bright_q, bright_d;
    logic        disp_on_q, disp_on_d;

    logic [3:0]  nxt_addr;
    logic [2:0]  nxt_pos;
    logic [7:0]  nxt_data;

    function automatic logic [7:0] seg7_code(input logic [3:0] d);
        logic [7:0] c;
        unique case (d)
            4'h0: c = 8'h3F;  4'h1: c = 8'h06;  4'h2: c = 8'h5B;  4'h3: c = 8'h4F;
            4'h4: c = 8'h66;  4'h5: c = 8'h6D;  4'h6: c = 8'h7D;  4'h7: c = 8'h07;
            4'h8: c = 8'h7F;  4'h9: c = 8'h6F;  4'hA: c = 8'h77;  4'hB: c = 8'h7C;
            4'hC: c = 8'h39;  4'hD: c = 8'h5E;  4'hE: c = 8'h79;  4'hF: c = 8'h71;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Data byte for the next G2 address: digit code at even, LED bit at odd addresses.
    always_comb begin
        nxt_addr = data_q ? addr_q + 4'd1 : 4'd0;
        nxt_pos  = nxt_addr[3:1];
        if (nxt_addr[0]) begin
            nxt_data = {7'b0, led_q[nxt_pos]};
        end else begin
            nxt_data = seg7_code(seg_q[nxt_pos]);
`ifdef TM1638_LEADZERO_BLANK_EN
            if (!nxt_pos[0] && seg_q[nxt_pos] == 4'h0) nxt_data = 8'h00;
`else
`endif
        end
    end

    // Next-state and registered output computation.
    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        valid_d   = valid_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        data_d    = data_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        led_d     = led_q;
        seg_d     = seg_q;
        bright_d  = bright_q;
        disp_on_d = disp_on_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (tick || (state_q == StDone && pending_q)) begin
                    pending_d = 1'b0;
                    led_d     = led;
                    seg_d     = '{seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7};
                    bright_d  = bright;
                    disp_on_d = disp_on;
                    state_d   = StG1;
                    stb_d     = 1'b0;
                    valid_d   = 1'b1;
                    byte_d    = 8'h40;
                end else begin
                    state_d = StIdle;
                end
            end
            StG1, StG2, StG3: begin
                pending_d = pending_q | tick;
                if (valid_q) begin
                    if (bus.byte_ready) begin
                        if (state_q == StG2 && !(data_q && addr_q == 4'd15)) begin
                            data_d = 1'b1;
                            addr_d = nxt_addr;
                            byte_d = nxt_data;
                        end else begin
                            // Last byte of the group: drain the shifter before strobing.
                            valid_d = 1'b0;
                            addr_d  = 4'd0;
                            data_d  = 1'b0;
                        end
                    end
                end else if (!bus.shifter_busy) begin
                    stb_d = 1'b1;
                    gap_d = '0;
                    if (state_q == StG1)      state_d = StGap1;
                    else if (state_q == StG2) state_d = StGap2;
                    else                      state_d = StGap3;
                end
            end
            StGap1, StGap2, StGap3: begin
                pending_d = pending_q | tick;
                if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
                    if (state_q == StGap1) begin
                        state_d = StG2;
                        stb_d   = 1'b0;
                        valid_d = 1'b1;
                        byte_d  = 8'hC0;
                        addr_d  = 4'd0;
                        data_d  = 1'b0;
                    end else if (state_q == StGap2) begin
                        state_d = StG3;
                        stb_d   = 1'b0;
                        valid_d = 1'b1;
                        byte_d  = {4'h8, disp_on_q, bright_q};
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            stb_q     <= 1'b1;
            valid_q   <= 1'b0;
            byte_q    <= 8'h00;
            addr_q    <= 4'd0;
            data_q    <= 1'b0;
            gap_q     <= '0;
            pending_q <= 1'b0;
            led_q     <= 8'h00;
            seg_q     <= '{default: 4'h0};
            bright_q  <= 3'd0;
            disp_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stb_q     <= stb_d;
            valid_q   <= valid_d;
            byte_q    <= byte_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            seg_q     <= seg_d;
            bright_q  <= bright_d;
            disp_on_q <= disp_on_d;
        end
    end

    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.stb        = stb_q;
    assign busy           = (state_q != StIdle);
    assign frame_done     = (state_q == StDone);

endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Directed bench for tm1638_frame_sched: byte stream, gaps, backpressure, pending ticks, reset.
module tb_tm1638_frame_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] led = 8'h00;
    logic [3:0] seg [8];
    logic [2:0] bright = 3'd0;
    logic       disp_on = 1'b0;
    logic       busy;
    logic       frame_done;

    tm1638_frame_sched_if bus();

    tm1638_frame_sched #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .tick(tick), .led(led),
        .seg0(seg[0]), .seg1(seg[1]), .seg2(seg[2]), .seg3(seg[3]),
        .seg4(seg[4]), .seg5(seg[5]), .seg6(seg[6]), .seg7(seg[7]),
        .bright(bright), .disp_on(disp_on), .bus(bus),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

`ifdef TM1638_LEADZERO_BLANK_EN
    localparam logic [7:0] Zero0 = 8'h00;
`else
    localparam logic [7:0] Zero0 = 8'h3F;
`endif

    // seg = 0,9,A,B,C,D,E,F  led = 5A  bright = 7  disp_on = 1
    logic [7:0] exp1 [19] = '{8'h40, 8'hC0,
        Zero0, 8'h00, 8'h6F, 8'h01, 8'h77, 8'h00, 8'h7C, 8'h01,
        8'h39, 8'h01, 8'h5E, 8'h00, 8'h79, 8'h01, 8'h71, 8'h00, 8'h8F};
    // seg = 1..8  led = 81  bright = 3  disp_on = 0
    logic [7:0] exp2 [19] = '{8'h40, 8'hC0,
        8'h06, 8'h01, 8'h5B, 8'h00, 8'h4F, 8'h00, 8'h66, 8'h00,
        8'h6D, 8'h00, 8'h7D, 8'h00, 8'h07, 8'h00, 8'h7F, 8'h01, 8'h83};

    int total = 0;
    int bad = 0;

    // Monitor state (written only here).
    logic [7:0] cap [$];
    int         gaps [$];
    int         done_cnt = 0;
    int         run = 0;
    int         hold_err = 0;
    int         stb_err = 0;
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pb = 8'h00;

    always @(negedge clk) begin
        if (!rst && bus.byte_valid && bus.byte_ready) cap.push_back(bus.byte_out);
        if (frame_done) done_cnt++;
        if (busy && bus.stb) begin
            run++;
        end else begin
            if (run > 0) gaps.push_back(run);
            run = 0;
        end
        if (!rst && pv && !pr && (!bus.byte_valid || bus.byte_out != pb)) hold_err++;
        if (bus.byte_valid && bus.stb) stb_err++;
        pv = bus.byte_valid;
        pr = bus.byte_ready;
        pb = bus.byte_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic set_inputs1();
        seg = '{4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        led = 8'h5A;
        bright = 3'd7;
        disp_on = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (bus.stb !== 1'b1) begin bad++; $display("FAIL reset_stb got %b want 1", bus.stb); end
        total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.byte_valid); end
        total++; if (bus.byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte got %h want 00", bus.byte_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", frame_done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_frame();
        int cb, db, gb;
        bit ok;
        set_inputs1();
        cb = cap.size(); db = done_cnt; gb = gaps.size();
        pulse_tick();
        total++; if (bus.stb !== 1'b0 || bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h40 || busy !== 1'b1) begin
            bad++; $display("FAIL first_byte got stb=%b v=%b b=%h busy=%b want 0 1 40 1",
                            bus.stb, bus.byte_valid, bus.byte_out, busy);
        end
        wait_idle(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got busy want idle"); end
        total++; if (cap.size() - cb !== 19) begin bad++; $display("FAIL basic_count got %0d want 19", cap.size() - cb); end
        for (int i = 0; i < 19 && cb + i < cap.size(); i++) begin
            total++; if (cap[cb + i] !== exp1[i]) begin
                bad++; $display("FAIL basic_byte%0d got %h want %h", i, cap[cb + i], exp1[i]);
            end
        end
        total++; if (done_cnt - db !== 1) begin bad++; $display("FAIL basic_done got %0d want 1", done_cnt - db); end
        total++; if (gaps.size() - gb !== 3) begin bad++; $display("FAIL basic_gaps got %0d want 3", gaps.size() - gb); end
        for (int i = gb; i < gaps.size(); i++) begin
            total++; if (gaps[i] < 2) begin bad++; $display("FAIL gap_len got %0d want >=2", gaps[i]); end
        end
    endtask

    task automatic test_seg_led_latch();
        int cb;
        bit ok;
        seg = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        led = 8'h81;
        bright = 3'd3;
        disp_on = 1'b0;
        cb = cap.size();
        pulse_tick();
        set_inputs1();  // must not affect the frame already started
        wait_idle(400, ok);
        total++; if (!ok || cap.size() - cb !== 19) begin
            bad++; $display("FAIL segled_count got %0d want 19", cap.size() - cb);
        end
        for (int i = 0; i < 19 && cb + i < cap.size(); i++) begin
            total++; if (cap[cb + i] !== exp2[i]) begin
                bad++; $display("FAIL segled_byte%0d got %h want %h", i, cap[cb + i], exp2[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int cb, hb;
        bit ok;
        set_inputs1();
        cb = cap.size(); hb = hold_err;
        pulse_tick();
        for (int i = 0; i < 100; i++) begin
            if (cap.size() - cb >= 4) break;
            step();
        end
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (bus.stb !== 1'b0 || bus.byte_valid !== 1'b1 || bus.byte_out !== exp1[4]) begin
                bad++; $display("FAIL stall%0d got stb=%b v=%b b=%h want 0 1 %h",
                                i, bus.stb, bus.byte_valid, bus.byte_out, exp1[4]);
            end
        end
        bus.byte_ready = 1'b1;
        wait_idle(400, ok);
        total++; if (!ok || cap.size() - cb !== 19) begin
            bad++; $display("FAIL stall_count got %0d want 19", cap.size() - cb);
        end
        for (int i = 0; i < 19 && cb + i < cap.size(); i++) begin
            total++; if (cap[cb + i] !== exp1[i]) begin
                bad++; $display("FAIL stall_byte%0d got %h want %h", i, cap[cb + i], exp1[i]);
            end
        end
        total++; if (hold_err - hb !== 0) begin bad++; $display("FAIL stall_hold got %0d want 0", hold_err - hb); end
    endtask

    task automatic test_shifter_busy();
        int cb;
        bit ok;
        cb = cap.size();
        pulse_tick();
        for (int i = 0; i < 50; i++) begin
            if (cap.size() - cb >= 1) break;
            step();
        end
        bus.shifter_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.stb !== 1'b0) begin bad++; $display("FAIL shbusy_stb%0d got %b want 0", i, bus.stb); end
        end
        bus.shifter_busy = 1'b0;
        step();
        total++; if (bus.stb !== 1'b1) begin bad++; $display("FAIL shbusy_rise got %b want 1", bus.stb); end
        wait_idle(400, ok);
        total++; if (!ok || cap.size() - cb !== 19) begin
            bad++; $display("FAIL shbusy_count got %0d want 19", cap.size() - cb);
        end
    endtask

    task automatic test_back_to_back();
        int cb, db, drops;
        cb = cap.size(); db = done_cnt; drops = 0;
        pulse_tick();
        for (int i = 0; i < 400; i++) begin
            tick = (i == 5 || i == 12 || i == 20);
            step();
            if (done_cnt - db >= 2) break;
            if (!busy) drops++;
        end
        tick = 1'b0;
        total++; if (drops !== 0) begin bad++; $display("FAIL b2b_busy_drop got %0d want 0", drops); end
        total++; if (done_cnt - db !== 2) begin bad++; $display("FAIL b2b_done got %0d want 2", done_cnt - db); end
        repeat (60) step();
        total++; if (done_cnt - db !== 2) begin bad++; $display("FAIL b2b_extra got %0d want 2", done_cnt - db); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got %b want 0", busy); end
        total++; if (cap.size() - cb !== 38) begin bad++; $display("FAIL b2b_count got %0d want 38", cap.size() - cb); end
    endtask

    task automatic test_tick_at_done();
        int db;
        bit ok;
        db = done_cnt;
        pulse_tick();
        for (int i = 0; i < 400; i++) begin
            if (frame_done) break;
            step();
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL done_reach got %b want 1", frame_done); end
        pulse_tick();
        total++; if (busy !== 1'b1 || bus.stb !== 1'b0 || bus.byte_out !== 8'h40) begin
            bad++; $display("FAIL done_tick got busy=%b stb=%b b=%h want 1 0 40", busy, bus.stb, bus.byte_out);
        end
        wait_idle(400, ok);
        total++; if (!ok || done_cnt - db !== 2) begin bad++; $display("FAIL done_tick_frames got %0d want 2", done_cnt - db); end
    endtask

    task automatic test_reset_mid_frame();
        int cb;
        bit ok;
        cb = cap.size();
        pulse_tick();
        tick = 1'b1;  // leaves a pending request that reset must discard
        step();
        tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cap.size() - cb >= 5) break;
            step();
        end
        rst = 1'b1;
        step();
        total++; if (bus.stb !== 1'b1 || bus.byte_valid !== 1'b0 || bus.byte_out !== 8'h00 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst got stb=%b v=%b b=%h busy=%b want 1 0 00 0",
                            bus.stb, bus.byte_valid, bus.byte_out, busy);
        end
        rst = 1'b0;
        repeat (3) step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_pending got %b want 0", busy); end
        pulse_tick();
        total++; if (bus.stb !== 1'b0 || bus.byte_out !== 8'h40) begin
            bad++; $display("FAIL midrst_restart got stb=%b b=%h want 0 40", bus.stb, bus.byte_out);
        end
        wait_idle(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_timeout got busy want idle"); end
    endtask

    initial begin
        seg = '{default: 4'h0};
        bus.byte_ready = 1'b1;
        bus.shifter_busy = 1'b0;
        test_reset();
        test_basic_frame();
        test_seg_led_latch();
        test_backpressure();
        test_shifter_busy();
        test_back_to_back();
        test_tick_at_done();
        test_reset_mid_frame();
        total++; if (stb_err !== 0) begin bad++; $display("FAIL valid_with_stb_high got %0d want 0", stb_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tm1638_frame_sched.md
TM1638_FRAME_SCHED -- requirements
Module: tm1638_frame_sched

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, minimum number of cycles stb stays high between command groups.
REQ-002 SHALL have port clk, input, 1, single clock, the kHz display clock domain.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port tick, input, 1, one-cycle refresh request.
REQ-005 SHALL have port led, input, 8, LED states; bit i drives LED i.
REQ-006 SHALL have ports seg0..seg7, input, 4 each, hex digit for display position 0..7.
REQ-007 SHALL have port bright, input, 3, brightness level.
REQ-008 SHALL have port disp_on, input, 1, display enable.
REQ-009 SHALL have port byte_out, output, 8, byte offered to the serial shifter.
REQ-010 SHALL have port byte_valid, output, 1, byte_out is valid.
REQ-011 SHALL have port byte_ready, input, 1, shifter accepts the byte this cycle.
REQ-012 SHALL have port shifter_busy, input, 1, shifter still clocking bits out.
REQ-013 SHALL have port stb, output, 1, TM1638 strobe, active-low.
REQ-014 SHALL have port busy, output, 1, a frame is in progress.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.

Function
REQ-016 SHALL transfer a byte only on a cycle with byte_valid=1 and byte_ready=1, holding byte_out stable while byte_valid=1 and byte_ready=0.
REQ-017 SHALL sequence the states IDLE -> G1 -> GAP1 -> G2 -> GAP2 -> G3 -> GAP3 -> DONE -> IDLE.
REQ-018 SHALL, in group G1, send the single byte 0x40 (write, auto-increment).
REQ-019 SHALL, in group G2, send 0xC0 followed by 16 data bytes at addresses 0..15, 17 bytes in all.
REQ-020 SHALL send at even address 2i the 7-segment code of seg_i, and at odd address 2i+1 the byte {7'b0, led[i]}.
REQ-021 SHALL use segment codes 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex).
REQ-022 SHALL, in group G3, send the single byte 0x80 | disp_on<<3 | bright.
REQ-023 SHALL latch led, seg0..seg7, bright and disp_on on the cycle a tick is accepted, keeping the frame unaffected by later input changes.
REQ-024 SHALL drive stb=0 and byte_valid=1 with the group's first byte on the cycle after a group state is entered; a tick in IDLE gives stb=0 and byte_out=0x40 on the next cycle.
REQ-025 SHALL present the next byte of the same group on the cycle after the previous byte is accepted, keeping stb low.
REQ-026 SHALL, after a group's last byte is accepted, drop byte_valid and keep stb low until shifter_busy is sampled 0, then raise stb.
REQ-027 SHALL hold stb high for at least GAP_CYCLES cycles in each GAP state before the next group begins.
REQ-028 SHALL pulse frame_done for exactly one cycle in DONE, for 19 bytes per frame.
REQ-029 SHALL hold busy=1 from the cycle after tick acceptance through DONE inclusive.
REQ-030 SHALL, on a tick while busy, set a one-deep pending flag; further ticks while pending are dropped.
REQ-031 SHALL, in DONE with pending=1, clear pending, latch the inputs and go straight to G1 without entering IDLE.
REQ-032 SHALL, on a tick in the same cycle as DONE, treat it as pending.
REQ-033 SHALL wrap the internal address counter from 15 to the G2 exit and never emit address 16.

Reset
REQ-034 SHALL, with rst=1 at a clk edge, set the state to IDLE, stb=1, byte_valid=0, byte_out=0x00, busy=0, frame_done=0, pending=0 and the address counter to 0.
REQ-035 SHALL apply reset mid-frame, even mid-byte, with the outputs above on the next cycle; rst has priority over tick.

Configuration
REQ-036 SHALL, with macro TM1638_LEADZERO_BLANK_EN defined, send 0x00 for even-position digits (seg0, seg2, seg4, seg6) equal to 0; without the macro, those digits SHALL send 0x3F.

Verification
REQ-037 SHALL pass: reset, tick, byte_ready always 1, shifter_busy always 0 -> byte stream 40,C0,16 data bytes,8F for bright=7 and disp_on=1; stb high between groups for ≥2 cycles; one frame_done pulse.
REQ-038 SHALL pass: seg0..7 = 1,2,3,4,5,6,7,8 and led = 8'h81 -> data bytes 06,01,5B,00,4F,00,66,00,6D,00,7D,00,07,00,7F,01.
REQ-039 SHALL pass: byte_ready low for 5 cycles on the 3rd data byte -> byte_out stable and stb low throughout; no byte lost or duplicated.
REQ-040 SHALL pass: shifter_busy high for 4 cycles after the last G1 byte -> stb rises only after shifter_busy falls.
REQ-041 SHALL pass: 3 ticks mid-frame -> exactly one extra frame, back-to-back, busy never dropping between the two frames.
REQ-042 SHALL pass: rst asserted during G2 -> stb=1, byte_valid=0 next cycle; the next tick restarts at 0x40.
